// File: rtl/operand_load_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : operand_load_pkg
//  Description : Shared state encodings, display constant and width helper
//                for the operand load controller and its neighbours.
//  Revision    : 1.0 - initial release
// ============================================================================
package operand_load_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_RESULT  = 2'd3
    } state_t;

    // All-ones makes the hex_code drivers show a blank display
    localparam logic [31:0] c_BLANK_DISP = 32'hFFFF_FFFF;

    // Ceiling log2, bounded loop so it stays elaboration-friendly
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_load_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : operand_load_ctrl_if
//  Description : Keypad, memory-write, MAC handshake and display bundle of
//                the operand load controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface operand_load_ctrl_if #(
    parameter int BANK_W = 1,
    parameter int ADDR_W = 3,
    parameter int ELEM_W = 16,
    parameter int RES_W  = 32
);
    logic              ns_button;
    logic              key_valid;
    logic [3:0]        key_data;
    logic              key_clr;
    logic              mem_we;
    logic [BANK_W-1:0] mem_bank;
    logic [ADDR_W-1:0] mem_addr;
    logic [ELEM_W-1:0] mem_wdata;
    logic              mac_start;
    logic              mac_done;
    logic [RES_W-1:0]  mac_result;
    logic [31:0]       disp_value;
    logic [1:0]        state_out;
    logic              busy;

    // Controller side
    modport master (
        input  ns_button, key_valid, key_data, key_clr, mac_done, mac_result,
        output mem_we, mem_bank, mem_addr, mem_wdata, mac_start,
               disp_value, state_out, busy
    );

    // Environment side (keypad, SRAM, MAC core, display)
    modport slave (
        output ns_button, key_valid, key_data, key_clr, mac_done, mac_result,
        input  mem_we, mem_bank, mem_addr, mem_wdata, mac_start,
               disp_value, state_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/operand_load_ctrl_button_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : button_sync_edge
//  Description : Two-flop synchroniser plus rising-edge detector; turns an
//                asynchronous push button into a single-cycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_sync_edge (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic din,
    output logic      pulse
);
    logic r_sync1;
    logic r_sync2;
    logic r_dly;

    // Synchronise the button and keep a delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    assign pulse = r_sync2 & ~r_dly;

endmodule
`default_nettype wire

// File: rtl/operand_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : operand_load_ctrl
//  Description : Assembles keypad digits into operand elements, writes them
//                bank by bank, starts the MAC and holds its result for the
//                hex display.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_load_ctrl
    import operand_load_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int DEPTH     = 8,
    parameter int ELEM_W    = 16,
    parameter int RES_W     = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    operand_load_ctrl_if.master bus
);
    localparam int BANK_W = (clog2(NUM_BANKS) < 1) ? 1 : clog2(NUM_BANKS);
    localparam int ADDR_W = clog2(DEPTH);
    localparam logic [BANK_W-1:0] c_LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic              w_commit;
    logic [ELEM_W-1:0] w_shift_key;
    logic [31:0]       w_disp_src;

    state_t            r_state;
    logic [BANK_W-1:0] r_bank;
    logic [ADDR_W-1:0] r_addr;
    logic [ELEM_W-1:0] r_shift;
    logic [RES_W-1:0]  r_result;
    logic              r_mem_we;
    logic [BANK_W-1:0] r_mem_bank;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ELEM_W-1:0] r_mem_wdata;
    logic              r_mac_start;
    logic              r_busy;
    logic [31:0]       r_disp;

    button_sync_edge u_btn (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.ns_button),
        .pulse (w_commit)
    );

    // New digit enters at the bottom; the oldest digit falls off the top
    assign w_shift_key = ELEM_W'({r_shift, bus.key_data});

    // Display source, registered below for one cycle of latency
    always_comb begin
        w_disp_src = c_BLANK_DISP;
        case (r_state)
            ST_LOAD:   w_disp_src = 32'(r_shift);
            ST_RESULT: w_disp_src = 32'(r_result);
            default:   w_disp_src = c_BLANK_DISP;
        endcase
    end

    // Control FSM with registered memory, MAC and display outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_bank      <= '0;
            r_addr      <= '0;
            r_shift     <= '0;
            r_result    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_bank  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mac_start <= 1'b0;
            r_busy      <= 1'b0;
            r_disp      <= c_BLANK_DISP;
        end else begin
            r_mem_we    <= 1'b0;
            r_mac_start <= 1'b0;
            r_disp      <= w_disp_src;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_LOAD;
                    r_bank  <= '0;
                    r_addr  <= '0;
                    r_shift <= '0;
                end
                ST_LOAD: begin
                    // Commit has priority: it writes the pre-key value
                    if (w_commit) begin
                        r_mem_we    <= 1'b1;
                        r_mem_bank  <= r_bank;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_shift;
                        r_shift     <= '0;
                        if (r_addr == c_LAST_ADDR) begin
                            r_addr <= '0;
                            if (r_bank == c_LAST_BANK) begin
                                r_bank      <= '0;
                                r_state     <= ST_COMPUTE;
                                r_mac_start <= 1'b1;
                                r_busy      <= 1'b1;
                            end else begin
                                r_bank <= r_bank + 1'b1;
                            end
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end else if (bus.key_clr) begin
                        r_shift <= '0;
                    end else if (bus.key_valid) begin
                        r_shift <= w_shift_key;
                    end
                end
                ST_COMPUTE: begin
                    if (bus.mac_done) begin
                        r_result <= bus.mac_result;
                        r_state  <= ST_RESULT;
                        r_busy   <= 1'b0;
                    end
                end
                ST_RESULT: begin
                    if (w_commit) begin
                        r_state <= ST_LOAD;
                        r_bank  <= '0;
                        r_addr  <= '0;
                        r_shift <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_we     = r_mem_we;
    assign bus.mem_bank   = r_mem_bank;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mac_start  = r_mac_start;
    assign bus.busy       = r_busy;
    assign bus.disp_value = r_disp;
    assign bus.state_out  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_operand_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_load_ctrl
//  Description : Directed, table-driven bench for operand_load_ctrl with the
//                default geometry and a 3x4x8-bit geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_load_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    operand_load_ctrl_if #(.BANK_W(1), .ADDR_W(3), .ELEM_W(16), .RES_W(32)) b1 ();
    operand_load_ctrl_if #(.BANK_W(2), .ADDR_W(2), .ELEM_W(8),  .RES_W(32)) b2 ();

    operand_load_ctrl #(.NUM_BANKS(2), .DEPTH(8), .ELEM_W(16), .RES_W(32)) u_dut1 (
        .clk (clk), .rst (rst), .bus (b1.master)
    );
    operand_load_ctrl #(.NUM_BANKS(3), .DEPTH(4), .ELEM_W(8), .RES_W(32)) u_dut2 (
        .clk (clk), .rst (rst), .bus (b2.master)
    );

    int errors = 0;
    int checks = 0;

    // Write / start observers
    int          n_wr1 = 0, n_st1 = 0, n_wr2 = 0, n_st2 = 0;
    logic        lb1;
    logic [2:0]  la1;
    logic [15:0] lw1;
    logic [1:0]  lb2, la2;
    logic [7:0]  lw2;

    always @(negedge clk) begin
        if (b1.mem_we) begin
            n_wr1 <= n_wr1 + 1;
            lb1   <= b1.mem_bank;
            la1   <= b1.mem_addr;
            lw1   <= b1.mem_wdata;
        end
        if (b1.mac_start) n_st1 <= n_st1 + 1;
        if (b2.mem_we) begin
            n_wr2 <= n_wr2 + 1;
            lb2   <= b2.mem_bank;
            la2   <= b2.mem_addr;
            lw2   <= b2.mem_wdata;
        end
        if (b2.mac_start) n_st2 <= n_st2 + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Key op encoding: [5]=key_valid [4]=key_clr [3:0]=key_data
    typedef struct packed {
        logic [35:0] ops;    // up to six ops, first op in the top slot
        logic [5:0]  cop;    // op driven in the cycle the commit acts
        logic [15:0] wdata;
        logic        bank;
        logic [2:0]  addr;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic [35:0] o, input logic [5:0] c,
                                input logic [15:0] w, input logic b, input logic [2:0] a);
        vec_t v;
        v.ops = o; v.cop = c; v.wdata = w; v.bank = b; v.addr = a;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic op1(input logic [5:0] op);
        b1.key_valid = op[5]; b1.key_clr = op[4]; b1.key_data = op[3:0];
        tick();
        b1.key_valid = 1'b0; b1.key_clr = 1'b0; b1.key_data = 4'h0;
    endtask

    // Button high from just after an edge: mem_we must appear after the 3rd edge
    task automatic press1(input logic [5:0] cop, input logic expw, input string nm);
        b1.ns_button = 1'b1;
        tick(); tick();
        chk({nm, " we early"}, 32'(b1.mem_we), 32'd0);
        b1.key_valid = cop[5]; b1.key_clr = cop[4]; b1.key_data = cop[3:0];
        tick();
        b1.key_valid = 1'b0; b1.key_clr = 1'b0; b1.key_data = 4'h0;
        chk({nm, " we"}, 32'(b1.mem_we), 32'(expw));
        b1.ns_button = 1'b0;
        tick();
        chk({nm, " we pulse"}, 32'(b1.mem_we), 32'd0);
        tick(); tick(); tick();
    endtask

    task automatic key2(input logic [3:0] d);
        b2.key_valid = 1'b1; b2.key_data = d;
        tick();
        b2.key_valid = 1'b0; b2.key_data = 4'h0;
    endtask

    task automatic press2(input logic do_done, input logic expw, input string nm);
        b2.ns_button = 1'b1;
        tick(); tick();
        chk({nm, " we early"}, 32'(b2.mem_we), 32'd0);
        tick();
        chk({nm, " we"}, 32'(b2.mem_we), 32'(expw));
        b2.ns_button = 1'b0;
        if (do_done) begin
            b2.mac_done = 1'b1; b2.mac_result = 32'hA5A5_A5A5;
        end
        tick();
        b2.mac_done = 1'b0; b2.mac_result = '0;
        chk({nm, " we pulse"}, 32'(b2.mem_we), 32'd0);
        tick(); tick(); tick();
    endtask

    initial begin
        b1.ns_button = 0; b1.key_valid = 0; b1.key_data = 0; b1.key_clr = 0;
        b1.mac_done = 0; b1.mac_result = '0;
        b2.ns_button = 0; b2.key_valid = 0; b2.key_data = 0; b2.key_clr = 0;
        b2.mac_done = 0; b2.mac_result = '0;

        // Commits 2..16 of the default geometry (bank0 addr1 .. bank1 addr7)
        vecs[0]  = mk({6'h21, 30'h0},                          6'h00, 16'h0001, 1'b0, 3'd1);
        vecs[1]  = mk({6'h22, 30'h0},                          6'h00, 16'h0002, 1'b0, 3'd2);
        vecs[2]  = mk({6'h25, 6'h26, 6'h27, 6'h28, 6'h29, 6'h0}, 6'h00, 16'h6789, 1'b0, 3'd3);
        vecs[3]  = mk({6'h24, 30'h0},                          6'h2F, 16'h0004, 1'b0, 3'd4);
        vecs[4]  = mk({6'h2A, 6'h2B, 24'h0},                   6'h10, 16'h00AB, 1'b0, 3'd5);
        vecs[5]  = mk({6'h23, 6'h2C, 6'h3E, 18'h0},            6'h00, 16'h0000, 1'b0, 3'd6);
        vecs[6]  = mk({6'h27, 6'h27, 6'h10, 6'h22, 12'h0},     6'h00, 16'h0002, 1'b0, 3'd7);
        vecs[7]  = mk({6'h28, 30'h0},                          6'h00, 16'h0008, 1'b1, 3'd0);
        vecs[8]  = mk({6'h29, 30'h0},                          6'h00, 16'h0009, 1'b1, 3'd1);
        vecs[9]  = mk({6'h2A, 30'h0},                          6'h00, 16'h000A, 1'b1, 3'd2);
        vecs[10] = mk({6'h2B, 30'h0},                          6'h00, 16'h000B, 1'b1, 3'd3);
        vecs[11] = mk({6'h2C, 30'h0},                          6'h00, 16'h000C, 1'b1, 3'd4);
        vecs[12] = mk({6'h2D, 30'h0},                          6'h00, 16'h000D, 1'b1, 3'd5);
        vecs[13] = mk({6'h2E, 30'h0},                          6'h00, 16'h000E, 1'b1, 3'd6);
        vecs[14] = mk({6'h2F, 30'h0},                          6'h00, 16'h000F, 1'b1, 3'd7);

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        chk("rst state", 32'(b1.state_out), 32'd0);
        chk("rst we", 32'(b1.mem_we), 32'd0);
        chk("rst start", 32'(b1.mac_start), 32'd0);
        chk("rst busy", 32'(b1.busy), 32'd0);
        chk("rst disp", b1.disp_value, 32'hFFFF_FFFF);
        chk("rst wdata", 32'(b1.mem_wdata), 32'd0);
        rst = 1'b1;
        tick();
        chk("idle to load", 32'(b1.state_out), 32'd1);

        // First element 1234 with exact commit latency
        op1(6'h21); op1(6'h22); op1(6'h23); op1(6'h24);
        tick();
        chk("disp pre commit", b1.disp_value, 32'h0000_1234);
        press1(6'h00, 1'b1, "first");
        chk("first count", 32'(n_wr1), 32'd1);
        chk("first bank", 32'(lb1), 32'd0);
        chk("first addr", 32'(la1), 32'd0);
        chk("first wdata", 32'(lw1), 32'h1234);
        chk("disp post commit", b1.disp_value, 32'd0);

        // Table-driven element fill
        for (int k = 0; k < 15; k++) begin
            for (int j = 0; j < 6; j++) op1(vecs[k].ops[35 - 6*j -: 6]);
            press1(vecs[k].cop, 1'b1, $sformatf("vec%0d", k));
            chk($sformatf("vec%0d wdata", k), 32'(lw1), 32'(vecs[k].wdata));
            chk($sformatf("vec%0d bank", k),  32'(lb1), 32'(vecs[k].bank));
            chk($sformatf("vec%0d addr", k),  32'(la1), 32'(vecs[k].addr));
            chk($sformatf("vec%0d count", k), 32'(n_wr1), 32'(k + 2));
        end
        chk("compute state", 32'(b1.state_out), 32'd2);
        chk("compute busy", 32'(b1.busy), 32'd1);
        chk("start once", 32'(n_st1), 32'd1);
        chk("compute disp", b1.disp_value, 32'hFFFF_FFFF);

        // Keys and commits ignored in COMPUTE, then MAC completes
        op1(6'h25);
        press1(6'h26, 1'b0, "compute press");
        chk("compute no write", 32'(n_wr1), 32'd16);
        chk("compute stays", 32'(b1.state_out), 32'd2);
        repeat (5) tick();
        b1.mac_done = 1'b1; b1.mac_result = 32'hDEAD_BEEF;
        tick();
        b1.mac_done = 1'b0; b1.mac_result = '0;
        chk("result state", 32'(b1.state_out), 32'd3);
        chk("result busy", 32'(b1.busy), 32'd0);
        tick();
        chk("result disp", b1.disp_value, 32'hDEAD_BEEF);
        chk("start still once", 32'(n_st1), 32'd1);

        // Held button from RESULT: one commit back to LOAD, no write
        b1.ns_button = 1'b1;
        repeat (50) tick();
        b1.ns_button = 1'b0;
        repeat (4) tick();
        chk("hold result->load", 32'(b1.state_out), 32'd1);
        chk("hold no write", 32'(n_wr1), 32'd16);
        op1(6'h25);
        press1(6'h00, 1'b1, "rerun");
        chk("rerun bank", 32'(lb1), 32'd0);
        chk("rerun addr", 32'(la1), 32'd0);
        chk("rerun wdata", 32'(lw1), 32'h0005);

        // Held button in LOAD: exactly one write
        op1(6'h21);
        b1.ns_button = 1'b1;
        repeat (50) tick();
        b1.ns_button = 1'b0;
        repeat (4) tick();
        chk("hold one write", 32'(n_wr1), 32'd18);
        chk("hold addr", 32'(la1), 32'd1);

        // Advance to bank1 addr3 then reset mid-load
        for (int i = 0; i < 9; i++) begin
            op1({2'b10, 4'(i)});
            press1(6'h00, 1'b1, "fill");
        end
        chk("fill bank", 32'(lb1), 32'd1);
        chk("fill addr", 32'(la1), 32'd2);
        op1(6'h23);
        rst = 1'b0;
        tick();
        chk("mid rst state", 32'(b1.state_out), 32'd0);
        chk("mid rst bank", 32'(b1.mem_bank), 32'd0);
        chk("mid rst addr", 32'(b1.mem_addr), 32'd0);
        chk("mid rst wdata", 32'(b1.mem_wdata), 32'd0);
        chk("mid rst disp", b1.disp_value, 32'hFFFF_FFFF);
        chk("mid rst busy", 32'(b1.busy), 32'd0);
        rst = 1'b1;
        b1.mac_done = 1'b1; b1.mac_result = 32'h1234_5678;
        tick(); tick();
        b1.mac_done = 1'b0; b1.mac_result = '0;
        chk("stale done state", 32'(b1.state_out), 32'd1);
        chk("stale done disp", b1.disp_value, 32'd0);
        op1(6'h29);
        press1(6'h00, 1'b1, "post rst");
        chk("post rst bank", 32'(lb1), 32'd0);
        chk("post rst addr", 32'(la1), 32'd0);
        chk("post rst wdata", 32'(lw1), 32'h0009);

        // Second geometry: 3 banks x 4 elements x 8 bits
        for (int i = 0; i < 12; i++) begin
            key2(4'hF); key2(4'(i)); key2(4'(i + 1));
            press2(i == 11, 1'b1, $sformatf("g2 w%0d", i));
            chk($sformatf("g2 w%0d bank", i),  32'(lb2), 32'(i / 4));
            chk($sformatf("g2 w%0d addr", i),  32'(la2), 32'(i % 4));
            chk($sformatf("g2 w%0d wdata", i), 32'(lw2), 32'({4'(i), 4'(i + 1)}));
        end
        chk("g2 writes", 32'(n_wr2), 32'd12);
        chk("g2 start once", 32'(n_st2), 32'd1);
        chk("g2 done with start", 32'(b2.state_out), 32'd3);
        chk("g2 result disp", b2.disp_value, 32'hA5A5_A5A5);
        press2(1'b0, 1'b0, "g2 restart");
        chk("g2 back to load", 32'(b2.state_out), 32'd1);
        key2(4'h3); key2(4'h4);
        press2(1'b0, 1'b1, "g2 reload");
        chk("g2 reload bank", 32'(lb2), 32'd0);
        chk("g2 reload addr", 32'(la2), 32'd0);
        chk("g2 reload wdata", 32'(lw2), 32'h34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_load_ctrl.md
Name: operand_load_ctrl

Overview:
- Parametrised successor to the keypad-to-SRAM operand loader in the FP MAC top level.
- Loads NUM_BANKS operand banks of DEPTH elements each. Each element is ELEM_W bits, assembled from several 4-bit keypad digits.
- Writes elements through a generic memory write port, then handshakes with the MAC datapath (start/done) and holds the result for the hex display.
- Sits between keyboard_read, the operand SRAMs, the MAC core and the hex_code display drivers.

Parameters:
- NUM_BANKS, 2, number of operand banks (A, B, ...); must be >= 1.
- DEPTH, 8, elements per bank; must be >= 2.
- ELEM_W, 16, element width in bits; multiple of 4, at most 32.
- RES_W, 32, MAC result width; at most 32.
- BANK_W, clog2(NUM_BANKS) with minimum 1, bank index width.
- ADDR_W, clog2(DEPTH), element address width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- ns_button  in  1  asynchronous "next/commit" push button, active-high
- key_valid  in  1  one-cycle strobe: key_data holds a new digit
- key_data  in  4  hex digit from the keypad
- key_clr  in  1  one-cycle strobe: discard the partially entered element
- mem_we  out  1  one-cycle write strobe
- mem_bank  out  BANK_W  target bank for the write
- mem_addr  out  ADDR_W  target element address
- mem_wdata  out  ELEM_W  element being written
- mac_start  out  1  one-cycle start pulse to the MAC core
- mac_done  in  1  MAC completion strobe
- mac_result  in  RES_W  MAC result; valid while mac_done is high
- disp_value  out  32  value routed to the four hex_code instances
- state_out  out  2  current state, for the arduino/debug output
- busy  out  1  high while in COMPUTE

Behaviour:
- Reset (rst low at a clk edge) sets:
  - state to IDLE; bank and address counters to 0; shift register to 0.
  - mem_we and mac_start to 0; mem_bank, mem_addr and mem_wdata to 0.
  - disp_value to 32'hFFFF_FFFF (blank); busy to 0; synchroniser flops to 0.
- Reset mid-operation abandons the run. No further writes or starts are issued, and a later mac_done is ignored.
- States and encodings: IDLE=0, LOAD=1, COMPUTE=2, RESULT=3. state_out shows the current encoding.
- IDLE: lasts exactly one cycle, then moves to LOAD with bank=0, addr=0 and the shift register cleared.
- Button handling:
  - ns_button passes through a 2-flop synchroniser followed by an edge-detect flop.
  - commit is high for one cycle when the synchronised level is 1 and the delayed level is 0.
  - Holding the button produces exactly one commit.
- LOAD, digit entry:
  - On key_valid, shift_reg <= {shift_reg[ELEM_W-5:0], key_data}.
  - Entering more than ELEM_W/4 digits drops the oldest ones.
  - On key_clr, shift_reg <= 0.
- LOAD, commit:
  - On the next clk edge: mem_we=1 for one cycle, with mem_bank, mem_addr and mem_wdata=shift_reg registered alongside it.
  - shift_reg is then cleared and addr increments.
- Latency: mem_we is high in the cycle following the 3rd rising clk edge at which ns_button is sampled high.
- Simultaneous events in LOAD:
  - commit together with key_valid: the commit uses the pre-key shift_reg and the digit is discarded.
  - commit together with key_clr: the commit wins and writes the old value.
  - key_valid together with key_clr: the clear wins.
- Address and bank wrap:
  - When addr==DEPTH-1 at commit, addr wraps to 0 and the bank increments.
  - When the bank is NUM_BANKS-1, the next state is COMPUTE and the bank returns to 0.
- COMPUTE:
  - mac_start=1 for exactly the first cycle in the state; busy=1 throughout.
  - Keys and commits are ignored.
  - When mac_done is seen, mac_result is latched and the next state is RESULT.
  - A mac_done arriving in the same cycle as mac_start is accepted.
  - There is no timeout.
- RESULT: holds the latched result. A commit starts a new run: LOAD with bank=0, addr=0 and the shift register cleared. Keys are ignored.
- disp_value, registered with one cycle of latency from its source:
  - LOAD: zero-extended shift_reg.
  - RESULT: zero-extended latched result.
  - IDLE and COMPUTE: 32'hFFFF_FFFF.
- mac_done outside COMPUTE is ignored.

Decomposition:
- Package operand_load_pkg holds the state encodings (IDLE/LOAD/COMPUTE/RESULT), the blank display constant 32'hFFFF_FFFF, and a clog2 helper function.
- The synchroniser plus edge detector is one natural sub-module, button_sync_edge (ports clk, rst, din, pulse). The top-level FP MAC and other panels reuse it.

Test Plan:
- Reset, then defaults (NUM_BANKS=2, DEPTH=8, ELEM_W=16): enter digits 1,2,3,4 then press ns_button → one mem_we with bank=0, addr=0, wdata=16'h1234, at the required 3-edge latency; disp_value is 0x00001234 before the commit and 0 after it.
- Commit 16 elements with values 0..15 → writes go to bank0 addr0..7 then bank1 addr0..7. After the 16th commit the state is COMPUTE and mac_start pulses exactly once.
- In COMPUTE, drive mac_done=1 with mac_result=32'hDEADBEEF after 5 cycles → state RESULT, disp_value=32'hDEADBEEF, busy=0. Keys pressed during COMPUTE cause no mem_we.
- Hold ns_button high for 50 cycles → exactly one commit. Enter digits 5,6,7,8,9 then commit → wdata=16'h6789. key_valid in the same cycle as the commit → the digit is not included.
- Assert rst for one cycle in the middle of LOAD (bank1, addr3) → all outputs return to reset values. The next commit writes bank0 addr0, and a stale mac_done is ignored.
- From RESULT, press ns_button → state LOAD with bank0 addr0. Rerun with NUM_BANKS=3, DEPTH=4, ELEM_W=8 → 12 writes, then mac_start.
